// File: rtl/bus_master_if_if.sv
// Shared-bus master port bundle: arbitration handshake, address/data
// phase and slave ready/read-data return.
interface bus_master_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/bus_master_if.sv
// Pipeline-to-bus master adapter: turns a single-cycle load/store request into
// the req_/grnt_/as_/rdy_ bus protocol, with a read-data hold buffer and watchdog.
//
// state  | meaning
// IDLE   | no transaction; accepts cpu_req when not flushed
// REQ    | bus_req_ asserted, waiting for grant (unbounded)
// ACCESS | address strobe asserted, waiting for rdy_ or watchdog expiry
// WAIT   | transfer finished but pipeline stalled; rd_buf held on cpu_rd_data
module bus_master_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              busy,
  output logic              err,
  bus_master_if_if.master   bus
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;

  localparam bit              TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              req_r, as_r, rw_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [DATA_W-1:0] rd_buf;
  logic [CNT_W-1:0]  counter;
  logic              accept, rdy_hit, tmo_hit;

  assign accept  = (state == IDLE) && cpu_req && !flush;
  assign rdy_hit = (state == ACCESS) && !bus.bus_rdy_;
  // ready in the same cycle as expiry is a successful transfer, not a timeout
  assign tmo_hit = TMO_EN && (state == ACCESS) && bus.bus_rdy_ && (counter == TMO_LAST);

  assign bus.bus_req_    = req_r;
  assign bus.bus_as_     = as_r;
  assign bus.bus_rw      = rw_r;
  assign bus.bus_addr    = addr_r;
  assign bus.bus_wr_data = wr_data_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    cpu_rd_data = rd_buf;
    case (state)
      IDLE: begin
        busy = accept;
        if (accept) state_nxt = REQ;
      end
      REQ: begin
        busy = 1'b1;
        if (!bus.bus_grnt_) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (rdy_hit) begin
          cpu_rd_data = bus.bus_rd_data;
          state_nxt   = stall ? WAIT : IDLE;
        end else if (tmo_hit) begin
          cpu_rd_data = '0;
          state_nxt   = stall ? WAIT : IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      WAIT: begin
        if (!stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_r     <= 1'b1;
      as_r      <= 1'b1;
      rw_r      <= 1'b1;
      addr_r    <= '0;
      wr_data_r <= '0;
      rd_buf    <= '0;
      err       <= 1'b0;
      counter   <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_r    <= cpu_addr;
            rw_r      <= cpu_rw;
            wr_data_r <= cpu_wr_data;
            req_r     <= 1'b0;
          end
        end
        REQ: begin
          if (!bus.bus_grnt_) begin
            as_r    <= 1'b0;
            counter <= '0;
          end
        end
        ACCESS: begin
          counter <= counter + 1'b1;
          if (rdy_hit) begin
            req_r <= 1'b1;
            as_r  <= 1'b1;
            if (rw_r) rd_buf <= bus.bus_rd_data;
          end else if (tmo_hit) begin
            err    <= 1'b1;
            req_r  <= 1'b1;
            as_r   <= 1'b1;
            rd_buf <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Scoreboard bench for bus_master_if: stimulus queues expected completions,
// a responsive slave model drives grant/ready, a negedge monitor checks.
module tb_bus_master_if;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_rw, stall, flush;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wr_data, cpu_rd_data;
  logic          busy, err;

  bus_master_if_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .stall(stall), .flush(flush),
    .cpu_rd_data(cpu_rd_data), .busy(busy), .err(err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            tmo;
    int            busy_n;
  } exp_t;

  exp_t q[$];

  // slave behaviour for the transaction in flight
  int            s_gnt = 0;
  int            s_rdy = 0;
  logic [DW-1:0] s_data = '0;

  initial begin
    int gcnt, acnt;
    gcnt = 0;
    acnt = 0;
    bus.bus_grnt_   = 1'b1;
    bus.bus_rdy_    = 1'b1;
    bus.bus_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.bus_rd_data = $urandom;
      if (rst) begin
        gcnt = 0; acnt = 0;
        bus.bus_grnt_ = 1'b1;
        bus.bus_rdy_  = 1'b1;
      end else begin
        if (!bus.bus_req_) begin
          if (gcnt >= s_gnt) bus.bus_grnt_ = 1'b0;
          else gcnt++;
        end else begin
          bus.bus_grnt_ = 1'b1;
          gcnt = 0;
        end
        if (!bus.bus_as_) begin
          if (acnt == s_rdy) begin
            bus.bus_rdy_    = 1'b0;
            bus.bus_rd_data = s_data;
          end else begin
            bus.bus_rdy_ = 1'b1;
          end
          acnt++;
        end else begin
          bus.bus_rdy_ = 1'b1;
          acnt = 0;
        end
      end
    end
  end

  // monitor: completion is the cycle the strobe is low and busy drops
  initial begin
    logic [DW-1:0] rbuf_m;
    int   brun;
    bit   err_exp, err_nxt, prev_done;
    exp_t e;
    rbuf_m = '0; brun = 0; err_exp = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        rbuf_m = '0; brun = 0; err_exp = 0; prev_done = 0;
      end else begin
        chk("err", err, err_exp);
        err_nxt = 0;
        if (prev_done) begin
          chk("req_released", bus.bus_req_, 1'b1);
          chk("as_released", bus.bus_as_, 1'b1);
        end
        prev_done = 0;
        if (busy) brun++;
        if (q.size() > 0 && !bus.bus_req_) begin
          chk("bus_addr", bus.bus_addr, q[0].addr);
          chk("bus_rw", bus.bus_rw, q[0].rw);
          chk("bus_wr_data", bus.bus_wr_data, q[0].wdata);
        end
        if (!bus.bus_as_ && !busy) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion: got completion expected none at %0t", $time);
          end else begin
            e = q.pop_front();
            chk("cpu_rd_data_done", cpu_rd_data, e.rdata);
            chk("busy_cycles", brun, e.busy_n);
            err_nxt = e.tmo;
            if (e.tmo) rbuf_m = '0;
            else if (e.rw) rbuf_m = e.rdata;
          end
          brun = 0;
          prev_done = 1;
        end else if (!busy && bus.bus_req_) begin
          chk("cpu_rd_data_hold", cpu_rd_data, rbuf_m);
        end
        err_exp = err_nxt;
      end
    end
  end

  task automatic start_txn(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] sd, input int g, input int r);
    exp_t e;
    bit   tmo;
    tmo    = (r >= TMO);
    s_gnt  = g;
    s_rdy  = r;
    s_data = sd;
    e.addr   = a;
    e.rw     = rw;
    e.wdata  = wd;
    e.tmo    = tmo;
    e.rdata  = tmo ? '0 : sd;
    e.busy_n = 2 + g + (tmo ? TMO - 1 : r);
    q.push_back(e);
    stall       = 1'b0;
    flush       = 1'b0;
    cpu_req     = 1'b1;
    cpu_rw      = rw;
    cpu_addr    = a;
    cpu_wr_data = wd;
    @(posedge clk); #1;
    cpu_req     = 1'b0;
    cpu_rw      = 1'($urandom);
    cpu_addr    = AW'($urandom);
    cpu_wr_data = $urandom;
  endtask

  task automatic finish_txn(input int stall_n, input bit fl);
    int n;
    n = 0;
    stall = (stall_n > 0);
    flush = fl;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (fl) flush = 1'($urandom);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL completion_wait: got no completion after %0d cycles expected one", n);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    repeat (stall_n) begin
      @(posedge clk); #1;
    end
    stall = 1'b0;
    flush = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic txn(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [DW-1:0] sd, input int g, input int r, input int stall_n, input bit fl);
    start_txn(rw, a, wd, sd, g, r);
    finish_txn(stall_n, fl);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    stall = 1'b0; flush = 1'b0;
    #12;
    chk("rst_req_", bus.bus_req_, 1'b1);
    chk("rst_as_", bus.bus_as_, 1'b1);
    chk("rst_rw", bus.bus_rw, 1'b1);
    chk("rst_addr", bus.bus_addr, '0);
    chk("rst_wr_data", bus.bus_wr_data, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_data", cpu_rd_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end

    txn(1'b1, 30'h0000100,  32'h0,        32'hDEADBEEF, 0, 0,  0, 1'b0);
    txn(1'b0, 30'h3FFFFFFF, 32'h12345678, 32'h0BADF00D, 2, 2,  0, 1'b0);
    txn(1'b1, 30'h0000200,  32'h0,        32'hA5A5A5A5, 1, 1,  4, 1'b0);
    txn(1'b1, 30'h0000300,  32'h0,        32'h11111111, 0, 20, 0, 1'b0);
    txn(1'b1, 30'h0000304,  32'h0,        32'h22222222, 1, 20, 2, 1'b0);
    txn(1'b1, 30'h0000308,  32'h0,        32'h33333333, 0, 3,  0, 1'b0);
    txn(1'b1, 30'h000030C,  32'h0,        32'h44444444, 3, 1,  0, 1'b1);

    // request with flush in IDLE must be ignored
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 30'h55; flush = 1'b1;
    #3;
    chk("flush_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("flush_req_", bus.bus_req_, 1'b1);
    cpu_req = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset in the middle of ACCESS
    start_txn(1'b1, 30'h0000400, 32'h0, 32'h66666666, 0, 9);
    n = 0;
    while (bus.bus_as_ && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_access", bus.bus_as_, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req_", bus.bus_req_, 1'b1);
    chk("arst_as_", bus.bus_as_, 1'b1);
    chk("arst_err", err, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rd_data", cpu_rd_data, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    txn(1'b1, 30'h0000404, 32'h0, 32'h77777777, 0, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), AW'($urandom), $urandom, $urandom,
          int'($urandom_range(3)), int'($urandom_range(5)),
          ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0,
          1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
